// File: rtl/minutes_hours_counter_pkg.sv
// Shared clock-display types, limits and helpers for the minutes/hours counter.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
        logic pm;
    } hour_t;

    localparam bcd_t       MIN_TENS_MAX = 4'd5;
    localparam bcd_t       MIN_ONES_MAX = 4'd9;
    localparam logic [7:0] HR24_MAX     = 8'd23;
    localparam logic [7:0] HR12_MIN     = 8'd1;
    localparam logic [7:0] HR12_MAX     = 8'd12;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned SECOND_HZ         = 1;
    localparam int unsigned CYCLES_PER_SECOND = CLK_HZ / SECOND_HZ;

    // Two BCD digits as a binary value, used for the hour range limits.
    function automatic logic [7:0] bcd_value(input bcd_t tens, input bcd_t ones);
        return ({4'd0, tens} * 8'd10) + {4'd0, ones};
    endfunction

endpackage

// File: rtl/minutes_hours_counter_if.sv
// Button/tick inputs and BCD display outputs of the minutes/hours counter.
interface minutes_hours_counter_if;
    import clock_pkg::*;

    logic inc_minutes;
    logic set_minutes;
    logic set_hours;
    bcd_t min_ones;
    bcd_t min_tens;
    bcd_t hr_ones;
    bcd_t hr_tens;
    logic pm;
    logic min_tick;

    modport master (
        output inc_minutes, set_minutes, set_hours,
        input  min_ones, min_tens, hr_ones, hr_tens, pm, min_tick
    );

    modport slave (
        input  inc_minutes, set_minutes, set_hours,
        output min_ones, min_tens, hr_ones, hr_tens, pm, min_tick
    );

endinterface

// File: rtl/minutes_hours_counter_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level with registered edge pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    assign level = sync2;

    // Resynchronize the input and emit one-cycle pulses on each settled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
            fall  <= prev & ~sync2;
        end
    end

endmodule

// File: rtl/minutes_hours_counter.sv
// BCD minutes/hours counter fed by the seconds counter's inc_minutes level.
// Define MINUTES_HOURS_AUTOREPEAT_EN to add hold-to-repeat on the set buttons.
module minutes_hours_counter
    import clock_pkg::*;
#(
    parameter int HOUR_MODE     = 24,
    parameter int REPEAT_DELAY  = int'(CYCLES_PER_SECOND / 2),
    parameter int REPEAT_PERIOD = int'(CYCLES_PER_SECOND / 4)
) (
    input logic                       clk_100MHz,
    input logic                       reset_n,
    minutes_hours_counter_if.slave    bus
);

    // Any HOUR_MODE other than 12 behaves as the 24-hour format.
    localparam hour_t HOUR_RESET = (HOUR_MODE == 12) ?
        '{tens: 4'd1, ones: 4'd2, pm: 1'b0} : '{tens: 4'd0, ones: 4'd0, pm: 1'b0};

    logic inc_level, inc_rise, inc_fall;
    logic set_min_level, set_min_rise, set_min_fall;
    logic set_hr_level, set_hr_rise, set_hr_fall;
    logic set_min_evt, set_hr_evt;

    bcd_t  min_ones_q, min_tens_q;
    hour_t hour_q, hour_once, hour_twice, hour_next;
    logic  tick_pending_q, min_tick_q;
    logic  tick_now, tick_defer, minute_adv, min_wrap, hour_carry;

    sync_edge_detect u_inc_sync (
        .clk(clk_100MHz), .rst_n(reset_n), .async_in(bus.inc_minutes),
        .level(inc_level), .rise(inc_rise), .fall(inc_fall)
    );

    sync_edge_detect u_set_min_sync (
        .clk(clk_100MHz), .rst_n(reset_n), .async_in(bus.set_minutes),
        .level(set_min_level), .rise(set_min_rise), .fall(set_min_fall)
    );

    sync_edge_detect u_set_hr_sync (
        .clk(clk_100MHz), .rst_n(reset_n), .async_in(bus.set_hours),
        .level(set_hr_level), .rise(set_hr_rise), .fall(set_hr_fall)
    );

`ifdef MINUTES_HOURS_AUTOREPEAT_EN
    localparam logic [26:0] REPEAT_FIRE   = 27'(REPEAT_DELAY - 1);
    localparam logic [26:0] REPEAT_RELOAD = 27'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [1:0] held;
    logic [1:0] repeat_pulse;
    logic       unused_sync;

    assign held        = {set_hr_level, set_min_level};
    assign unused_sync = ^{inc_level, inc_rise, set_min_fall, set_hr_fall};

    for (genvar g = 0; g < 2; g++) begin : g_repeat
        logic [26:0] hold_cnt;
        logic        pulse_q;

        // Fire once after the hold delay, then every repeat period until release.
        always_ff @(posedge clk_100MHz or negedge reset_n) begin
            if (!reset_n) begin
                hold_cnt <= '0;
                pulse_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (!held[g]) begin
                    hold_cnt <= '0;
                end else if (hold_cnt == REPEAT_FIRE) begin
                    pulse_q  <= 1'b1;
                    hold_cnt <= REPEAT_RELOAD;
                end else begin
                    hold_cnt <= hold_cnt + 27'd1;
                end
            end
        end

        assign repeat_pulse[g] = pulse_q;
    end

    assign set_min_evt = set_min_rise | repeat_pulse[0];
    assign set_hr_evt  = set_hr_rise  | repeat_pulse[1];
`else
    logic unused_sync;

    // Button levels and the repeat timing only matter for hold-to-repeat.
    assign unused_sync = ^{inc_level, inc_rise, set_min_fall, set_hr_fall,
                           set_min_level, set_hr_level,
                           REPEAT_DELAY[0], REPEAT_PERIOD[0]};

    assign set_min_evt = set_min_rise;
    assign set_hr_evt  = set_hr_rise;
`endif

    // One hour step in the configured format; pm flips on 11 -> 12.
    function automatic hour_t hour_step(input hour_t h);
        hour_t      n;
        logic [7:0] value;
        n     = h;
        value = bcd_value(h.tens, h.ones);
        if (HOUR_MODE == 12) begin
            if (value == HR12_MAX) begin
                n.tens = 4'd0;
                n.ones = HR12_MIN[3:0];
            end else if (value == HR12_MAX - 8'd1) begin
                n.tens = 4'd1;
                n.ones = 4'd2;
                n.pm   = ~h.pm;
            end else if (h.ones == 4'd9) begin
                n.tens = h.tens + 4'd1;
                n.ones = 4'd0;
            end else begin
                n.ones = h.ones + 4'd1;
            end
        end else begin
            if (value == HR24_MAX) begin
                n.tens = 4'd0;
                n.ones = 4'd0;
            end else if (h.ones == 4'd9) begin
                n.tens = h.tens + 4'd1;
                n.ones = 4'd0;
            end else begin
                n.ones = h.ones + 4'd1;
            end
        end
        return n;
    endfunction

    // A set_minutes event wins the cycle; a coincident tick waits one cycle.
    always_comb begin
        tick_now   = 1'b0;
        tick_defer = 1'b0;
        if (set_min_evt) begin
            tick_defer = inc_fall | tick_pending_q;
        end else begin
            tick_now = inc_fall | tick_pending_q;
        end
        minute_adv = set_min_evt | tick_now;
        min_wrap   = (min_tens_q == MIN_TENS_MAX) && (min_ones_q == MIN_ONES_MAX);
        hour_carry = tick_now & min_wrap;
        hour_once  = hour_step(hour_q);
        hour_twice = hour_step(hour_once);
        case ({set_hr_evt, hour_carry})
            2'b01, 2'b10: hour_next = hour_once;
            2'b11:        hour_next = hour_twice;
            default:      hour_next = hour_q;
        endcase
    end

    // Time-of-day registers, the pending tick and the minute advance pulse.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            min_ones_q     <= 4'd0;
            min_tens_q     <= 4'd0;
            hour_q         <= HOUR_RESET;
            tick_pending_q <= 1'b0;
            min_tick_q     <= 1'b0;
        end else begin
            tick_pending_q <= tick_defer;
            min_tick_q     <= minute_adv;
            hour_q         <= hour_next;
            if (minute_adv) begin
                if (min_wrap) begin
                    min_ones_q <= 4'd0;
                    min_tens_q <= 4'd0;
                end else if (min_ones_q == MIN_ONES_MAX) begin
                    min_ones_q <= 4'd0;
                    min_tens_q <= min_tens_q + 4'd1;
                end else begin
                    min_ones_q <= min_ones_q + 4'd1;
                end
            end
        end
    end

    assign bus.min_ones = min_ones_q;
    assign bus.min_tens = min_tens_q;
    assign bus.hr_ones  = hour_q.ones;
    assign bus.hr_tens  = hour_q.tens;
    assign bus.pm       = (HOUR_MODE == 12) ? hour_q.pm : 1'b0;
    assign bus.min_tick = min_tick_q;

endmodule

// File: tb/tb_minutes_hours_counter.sv
// Directed bench for minutes_hours_counter: one 24-hour and one 12-hour instance.
module tb_minutes_hours_counter;

    logic clk_100MHz;
    logic reset_n;
    int   checks;
    int   passed;
    int   ticks24;
    int   ticks12;

    minutes_hours_counter_if if24 ();
    minutes_hours_counter_if if12 ();

    minutes_hours_counter #(.HOUR_MODE(24), .REPEAT_DELAY(100), .REPEAT_PERIOD(20)) dut24 (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .bus(if24.slave)
    );

    minutes_hours_counter #(.HOUR_MODE(12), .REPEAT_DELAY(100), .REPEAT_PERIOD(20)) dut12 (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .bus(if12.slave)
    );

    // 100 MHz board clock
    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    // Count min_tick pulses away from the active edge
    always @(negedge clk_100MHz) begin
        if (if24.min_tick === 1'b1) ticks24++;
        if (if12.min_tick === 1'b1) ticks12++;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] time24();
        return {if24.hr_tens, if24.hr_ones, if24.min_tens, if24.min_ones};
    endfunction

    function automatic logic [15:0] time12();
        return {if12.hr_tens, if12.hr_ones, if12.min_tens, if12.min_ones};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic drive_set(input bit use12, input bit hours, input logic val);
        if (use12) begin
            if (hours) if12.set_hours = val; else if12.set_minutes = val;
        end else begin
            if (hours) if24.set_hours = val; else if24.set_minutes = val;
        end
    endtask

    task automatic press(input bit use12, input bit hours, input int times);
        for (int i = 0; i < times; i++) begin
            drive_set(use12, hours, 1'b1);
            cycles(4);
            drive_set(use12, hours, 1'b0);
            cycles(4);
        end
    endtask

    task automatic pulse_inc(input bit use12, input int high_cycles);
        if (use12) if12.inc_minutes = 1'b1; else if24.inc_minutes = 1'b1;
        cycles(high_cycles);
        if (use12) if12.inc_minutes = 1'b0; else if24.inc_minutes = 1'b0;
        cycles(8);
    endtask

    task automatic test_reset();
        int t0;
        reset_n = 1'b0;
        cycles(3);
        checks++; if (time24() !== 16'h0000) $display("[TB] FAIL reset_time24: got %h expected 0000", time24()); else passed++;
        checks++; if (time12() !== 16'h1200) $display("[TB] FAIL reset_time12: got %h expected 1200", time12()); else passed++;
        checks++; if (if12.pm !== 1'b0) $display("[TB] FAIL reset_pm12: got %b expected 0", if12.pm); else passed++;
        checks++; if (if24.min_tick !== 1'b0) $display("[TB] FAIL reset_min_tick: got %b expected 0", if24.min_tick); else passed++;
        reset_n = 1'b1;
        t0 = ticks24;
        cycles(1000);
        checks++; if (time24() !== 16'h0000) $display("[TB] FAIL idle_time24: got %h expected 0000", time24()); else passed++;
        checks++; if (ticks24 - t0 !== 0) $display("[TB] FAIL idle_ticks: got %0d expected 0", ticks24 - t0); else passed++;
    endtask

    task automatic test_long_pulse();
        int t0;
        t0 = ticks24;
        if24.inc_minutes = 1'b1;
        cycles(10_000);
        checks++; if (time24() !== 16'h0000) $display("[TB] FAIL rise_no_change: got %h expected 0000", time24()); else passed++;
        checks++; if (ticks24 - t0 !== 0) $display("[TB] FAIL rise_no_tick: got %0d expected 0", ticks24 - t0); else passed++;
        if24.inc_minutes = 1'b0;
        cycles(3);
        checks++; if (time24() !== 16'h0000) $display("[TB] FAIL tick_too_early: got %h expected 0000", time24()); else passed++;
        checks++; if (if24.min_tick !== 1'b0) $display("[TB] FAIL tick_pulse_early: got %b expected 0", if24.min_tick); else passed++;
        cycles(1);
        checks++; if (time24() !== 16'h0001) $display("[TB] FAIL tick_time: got %h expected 0001", time24()); else passed++;
        checks++; if (if24.min_tick !== 1'b1) $display("[TB] FAIL tick_pulse: got %b expected 1", if24.min_tick); else passed++;
        cycles(1);
        checks++; if (if24.min_tick !== 1'b0) $display("[TB] FAIL tick_pulse_width: got %b expected 0", if24.min_tick); else passed++;
        cycles(20);
        checks++; if (ticks24 - t0 !== 1) $display("[TB] FAIL tick_count: got %0d expected 1", ticks24 - t0); else passed++;
    endtask

    task automatic test_wrap24();
        int t0;
        press(1'b0, 1'b1, 23);
        checks++; if (time24() !== 16'h2301) $display("[TB] FAIL preload_hours24: got %h expected 2301", time24()); else passed++;
        press(1'b0, 1'b0, 58);
        checks++; if (time24() !== 16'h2359) $display("[TB] FAIL preload_2359: got %h expected 2359", time24()); else passed++;
        t0 = ticks24;
        pulse_inc(1'b0, 20);
        checks++; if (time24() !== 16'h0000) $display("[TB] FAIL wrap24_time: got %h expected 0000", time24()); else passed++;
        checks++; if (ticks24 - t0 !== 1) $display("[TB] FAIL wrap24_ticks: got %0d expected 1", ticks24 - t0); else passed++;
    endtask

    task automatic test_wrap12();
        press(1'b1, 1'b1, 11);
        checks++; if (time12() !== 16'h1100) $display("[TB] FAIL preload_hours12: got %h expected 1100", time12()); else passed++;
        press(1'b1, 1'b0, 59);
        checks++; if (time12() !== 16'h1159) $display("[TB] FAIL preload_1159: got %h expected 1159", time12()); else passed++;
        checks++; if (if12.pm !== 1'b0) $display("[TB] FAIL preload_pm12: got %b expected 0", if12.pm); else passed++;
        pulse_inc(1'b1, 20);
        checks++; if (time12() !== 16'h1200) $display("[TB] FAIL wrap12_time: got %h expected 1200", time12()); else passed++;
        checks++; if (if12.pm !== 1'b1) $display("[TB] FAIL wrap12_pm: got %b expected 1", if12.pm); else passed++;
        press(1'b1, 1'b1, 1);
        checks++; if (time12() !== 16'h0100) $display("[TB] FAIL set12_after_noon: got %h expected 0100", time12()); else passed++;
        checks++; if (if12.pm !== 1'b1) $display("[TB] FAIL set12_pm_kept: got %b expected 1", if12.pm); else passed++;
    endtask

    task automatic test_set_no_carry();
        press(1'b0, 1'b1, 10);
        press(1'b0, 1'b0, 59);
        checks++; if (time24() !== 16'h1059) $display("[TB] FAIL preload_1059: got %h expected 1059", time24()); else passed++;
        press(1'b0, 1'b0, 1);
        checks++; if (time24() !== 16'h1000) $display("[TB] FAIL set_wrap_no_carry: got %h expected 1000", time24()); else passed++;
    endtask

    task automatic test_back_to_back();
        press(1'b0, 1'b0, 5);
        checks++; if (time24() !== 16'h1005) $display("[TB] FAIL preload_1005: got %h expected 1005", time24()); else passed++;
        if24.inc_minutes = 1'b1;
        cycles(20);
        if24.inc_minutes = 1'b0;
        if24.set_minutes = 1'b1;
        cycles(3);
        checks++; if (time24() !== 16'h1005) $display("[TB] FAIL b2b_before: got %h expected 1005", time24()); else passed++;
        cycles(1);
        checks++; if (time24() !== 16'h1006) $display("[TB] FAIL b2b_set_first: got %h expected 1006", time24()); else passed++;
        checks++; if (if24.min_tick !== 1'b1) $display("[TB] FAIL b2b_tick1: got %b expected 1", if24.min_tick); else passed++;
        cycles(1);
        checks++; if (time24() !== 16'h1007) $display("[TB] FAIL b2b_pending_tick: got %h expected 1007", time24()); else passed++;
        checks++; if (if24.min_tick !== 1'b1) $display("[TB] FAIL b2b_tick2: got %b expected 1", if24.min_tick); else passed++;
        cycles(1);
        checks++; if (if24.min_tick !== 1'b0) $display("[TB] FAIL b2b_tick_end: got %b expected 0", if24.min_tick); else passed++;
        if24.set_minutes = 1'b0;
        cycles(10);
        checks++; if (time24() !== 16'h1007) $display("[TB] FAIL b2b_settled: got %h expected 1007", time24()); else passed++;
    endtask

    task automatic test_simultaneous();
        if24.set_minutes = 1'b1;
        if24.set_hours   = 1'b1;
        cycles(4);
        if24.set_minutes = 1'b0;
        if24.set_hours   = 1'b0;
        cycles(4);
        checks++; if (time24() !== 16'h1108) $display("[TB] FAIL both_sets: got %h expected 1108", time24()); else passed++;
        press(1'b0, 1'b0, 51);
        checks++; if (time24() !== 16'h1159) $display("[TB] FAIL preload_1159_24: got %h expected 1159", time24()); else passed++;
        if24.inc_minutes = 1'b1;
        cycles(20);
        if24.inc_minutes = 1'b0;
        if24.set_hours   = 1'b1;
        cycles(10);
        if24.set_hours = 1'b0;
        cycles(8);
        checks++; if (time24() !== 16'h1300) $display("[TB] FAIL carry_plus_set_hours: got %h expected 1300", time24()); else passed++;
    endtask

    task automatic test_reset_mid_tick();
        int t0;
        if24.inc_minutes = 1'b1;
        cycles(20);
        t0 = ticks24;
        if24.inc_minutes = 1'b0;
        cycles(1);
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        cycles(10);
        checks++; if (time24() !== 16'h0000) $display("[TB] FAIL midtick_reset_time: got %h expected 0000", time24()); else passed++;
        checks++; if (ticks24 - t0 !== 0) $display("[TB] FAIL midtick_no_tick: got %0d expected 0", ticks24 - t0); else passed++;
        checks++; if (time12() !== 16'h1200) $display("[TB] FAIL midtick_reset12: got %h expected 1200", time12()); else passed++;
        checks++; if (if12.pm !== 1'b0) $display("[TB] FAIL midtick_pm12: got %b expected 0", if12.pm); else passed++;
    endtask

    task automatic test_hold_button();
        logic [15:0] expected;
`ifdef MINUTES_HOURS_AUTOREPEAT_EN
        expected = 16'h0005;
`else
        expected = 16'h0001;
`endif
        if24.set_minutes = 1'b1;
        cycles(165);
        if24.set_minutes = 1'b0;
        cycles(10);
        checks++; if (time24() !== expected) $display("[TB] FAIL hold_set_minutes: got %h expected %h", time24(), expected); else passed++;
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        ticks24 = 0;
        ticks12 = 0;
        reset_n = 1'b0;
        if24.inc_minutes = 1'b0; if24.set_minutes = 1'b0; if24.set_hours = 1'b0;
        if12.inc_minutes = 1'b0; if12.set_minutes = 1'b0; if12.set_hours = 1'b0;
        @(negedge clk_100MHz);
        test_reset();
        test_long_pulse();
        test_wrap24();
        test_wrap12();
        test_reset_mid_tick();
        test_set_no_carry();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_tick();
        test_hold_button();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/minutes_hours_counter.md
Name: minutes_hours_counter

Overview:
- Consumer end of the seconds-to-minutes interface: takes the `inc_minutes` level from the 1 Hz seconds counter and maintains minutes and hours as BCD digits for the seven-segment display mux.
- Runs on the 100 MHz board clock. `inc_minutes` is treated as an asynchronous input and passes through a 2-FF synchronizer and an edge detector.
- Also accepts debounced set-button requests for setting the time.

Parameters:
- HOUR_MODE, 24, hour format: 24 gives 00–23; 12 gives 12,01–11 with a `pm` flag. Any other value is illegal.
- REPEAT_DELAY, 50_000_000, cycles a set input must be held before auto-repeat starts. Used only with the optional feature.
- REPEAT_PERIOD, 25_000_000, cycles between auto-repeat increments. Used only with the optional feature.

Ports:
- clk_100MHz  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- inc_minutes  input  1  level from the seconds counter; high while seconds = 59; asynchronous to clk_100MHz
- set_minutes  input  1  debounced button level; increments minutes
- set_hours  input  1  debounced button level; increments hours
- min_ones  output  4  BCD minutes units, 0–9
- min_tens  output  4  BCD minutes tens, 0–5
- hr_ones  output  4  BCD hours units
- hr_tens  output  4  BCD hours tens, 0–2
- pm  output  1  PM flag; only meaningful when HOUR_MODE=12, otherwise tied to 0
- min_tick  output  1  one-cycle pulse on every minute advance, whether from a tick or from a set

Behaviour:
- **Reset** (reset_n low, asynchronous): all outputs and internal flops clear immediately.
  - HOUR_MODE=24: time = 00:00.
  - HOUR_MODE=12: time = 12:00, pm=0.
  - Synchronizer flops reset to 0, so no spurious edge is seen after reset release.
- **Tick detection:**
  - inc_minutes → sync1 → sync2 → prev.
  - A tick fires when prev=1 and sync2=0, i.e. the falling edge, which marks the seconds counter wrapping 59→0.
  - Minutes update on the clock edge 3 cycles after the first clk_100MHz edge that samples inc_minutes low.
  - Exactly one tick per inc_minutes pulse, however long the pulse lasts.
- **Minute advance:**
  - min_ones increments 0–9; on 9 it wraps to 0 and min_tens increments.
  - min_tens 5 with min_ones 9 wraps to 00.
  - A tick-driven wrap carries into the hours. A set-driven wrap does not carry.
- **Hour advance, 24-hour mode:** 00→01…→09→10…→23→00; days are not tracked.
- **Hour advance, 12-hour mode:**
  - Sequence 12→01→…→11→12.
  - pm toggles on the 11→12 transition for both tick and set advances.
- **Set inputs** (default build, feature off):
  - A 2-FF-synchronized rising edge on set_minutes or set_hours gives exactly one increment.
  - Holding the button does nothing further.
- **Simultaneous events:**
  - Tick and set_minutes in the same cycle: the set is applied first; the tick is held in a pending flop and applied the next cycle. Result is +2 minutes, with carry evaluated at tick time.
  - set_hours and set_minutes in the same cycle: both apply, with no carry from minutes.
  - Tick carry into hours and set_hours in the same cycle: both apply, giving +2 hours.
- **Pending tick:**
  - At most one tick is pending.
  - A second tick arriving while one is pending cannot occur, since ticks are ≥1 s apart.
- **Reset mid-operation:** reset discards pending ticks and in-flight edges.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: `MINUTES_HOURS_AUTOREPEAT_EN`.
- Defined:
  - Each set input gets a hold counter, 27 bits.
  - First increment on the rising edge.
  - If still held after REPEAT_DELAY cycles, a further increment, then one every REPEAT_PERIOD cycles until release.
  - Release clears the counter.
  - Reset clears the counter.
- Undefined: one increment per press only; the counters are not synthesized.

Decomposition:
- Shared package `clock_pkg`:
  - BCD digit typedef, 4 bits.
  - Constants MIN_TENS_MAX=5, MIN_ONES_MAX=9, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12.
  - Default 1 Hz / 100 MHz cycle constants.
- One natural sub-module: `sync_edge_detect`.
  - 2-FF synchronizer plus rise/fall pulse outputs.
  - Instantiated three times: inc_minutes, set_minutes, set_hours.
- Counting logic stays in the top module.

Test Plan:
- Reset with HOUR_MODE=24, release, hold inc_minutes low for 1000 cycles → outputs 00:00, min_tick never asserts.
- Drive an inc_minutes pulse 10_000 cycles long from 00:00 → exactly one min_tick, 3 cycles after the falling edge; time 00:01; no change on the rising edge.
- Preload 23:59 via sets, apply a tick → 00:00 with a single min_tick. With HOUR_MODE=12, preload 11:59 pm=0, apply a tick → 12:00 pm=1.
- Apply set_minutes at 10:59 → 10:00 with hours unchanged. Apply a tick and a set_minutes rising edge in the same cycle at 10:05 → 10:06, then 10:07 one cycle later.
- Assert reset_n low for 1 cycle mid-tick, 1 cycle after the inc_minutes falling edge → time 00:00, no increment after release.
- With MINUTES_HOURS_AUTOREPEAT_EN, REPEAT_DELAY=100, REPEAT_PERIOD=20, hold set_minutes 165 cycles from 00:00 → 00:05 (1 edge + at 100 + at 120, 140, 160).
